// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the byte-stream memory loader.
package mem_loader_pkg;

  // Loader sequencing: idle, streaming data words, awaiting checksum, finished.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of stream bytes packed into one memory word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-stream to memory-word loader: packs bytes little-endian into words,
// writes them from address 0 upward, then validates a trailing checksum byte.
// The CPU is held in reset for the whole load.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst_n
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]     eff_len_q, eff_len_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [7:0]              sum_q, sum_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic [ADDR_WIDTH:0]     eff_len;
  logic [7:0]              chk_sum;

  assign s_ready   = (state_q == LOAD) || (state_q == CHECK);
  assign busy      = s_ready;
  assign cpu_rst_n = ~busy;
  assign accept    = s_valid && s_ready;
  // Requests beyond the memory size are clamped so the address never wraps.
  assign eff_len   = (length > DEPTH) ? DEPTH : length;
  assign chk_sum   = sum_q + s_data;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign done      = done_q;
  assign error     = error_q;

  // State and datapath registers; reset aborts any load without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      eff_len_q   <= '0;
      byte_idx_q  <= '0;
      pack_q      <= '0;
      sum_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      eff_len_q   <= eff_len_d;
      byte_idx_q  <= byte_idx_d;
      pack_q      <= pack_d;
      sum_q       <= sum_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic: start handling, byte packing, word writes, checksum test.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    eff_len_d   = eff_len_q;
    byte_idx_d  = byte_idx_q;
    pack_d      = pack_q;
    sum_d       = sum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          error_d    = 1'b0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          pack_d     = '0;
          sum_d      = '0;
          eff_len_d  = eff_len;
          state_d    = (eff_len == '0) ? CHECK : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          sum_d = sum_q + s_data;
          pack_d[int'(byte_idx_q) * 8 +: 8] = s_data;
          if (byte_idx_q == LAST_IDX) begin
            // Word complete: register the write so address/data are stable with the strobe.
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = pack_d;
            word_cnt_d  = word_cnt_q + (ADDR_WIDTH + 1)'(1);
            byte_idx_d  = '0;
            if (word_cnt_d == eff_len_q) begin
              state_d = CHECK;
            end
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      CHECK: begin
        if (accept) begin
          error_d = (chk_sum != 8'd0);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a write scoreboard.
module tb_mem_loader;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   length;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_rst_n;

  mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .length    (length),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  logic [7:0] tbl [4] = '{8'h34, 8'h12, 8'h78, 8'h56};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      check("write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", 32'(mem_wdata), 32'(e.data));
        $display("write addr=%0h data=%04h", mem_addr, mem_wdata);
      end
    end
  end

  // Present one byte (after an optional idle gap) and wait until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   cyc;
    logic rdy;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    cyc     = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!rdy && cyc < 50);
    if (!rdy) begin
      n_checks++;
      n_fails++;
      $display("FAIL byte_timeout: observed s_ready=0 expected 1 within 50 cycles");
    end
    s_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = (AW + 1)'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("start_s_ready", 32'(s_ready), 32'd1);
    check("start_error_clr", 32'(error), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: table bytes, mode 1: incrementing bytes. ck_ovr < 0 sends a correct checksum.
  task automatic do_load(input int len, input int mode, input int ck_ovr,
                         input bit rand_gap, input int pulse_at);
    int            eff;
    int            idx;
    logic [7:0]    sum;
    logic [7:0]    b;
    logic [7:0]    ck;
    logic [7:0]    tot;
    logic [DW-1:0] w;
    eff = (len > 256) ? 256 : len;
    sum = 8'd0;
    w   = '0;
    do_start(len);
    for (int wi = 0; wi < eff; wi++) begin
      for (int k = 0; k < 2; k++) begin
        idx = wi * 2 + k;
        b   = (mode == 0) ? tbl[idx % 4] : 8'(idx);
        w[8*k +: 8] = b;
        sum = sum + b;
        if (k == 1) exp_q.push_back(wr_t'{addr: AW'(wi), data: w});
        if (idx == pulse_at) begin
          start  = 1'b1;
          length = (AW + 1)'(1);
        end
        send_byte(b, rand_gap ? int'($urandom_range(0, 2)) : 0);
        if (idx == pulse_at) begin
          start = 1'b0;
          @(negedge clk);
          check("pulse_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
          check("pulse_busy", 32'(busy), 32'd1);
          @(posedge clk);
          #1;
        end
      end
    end
    @(negedge clk);
    check("pre_ck_done", 32'(done), 32'd0);
    check("pre_ck_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    ck  = (ck_ovr < 0) ? 8'(~sum + 8'd1) : 8'(ck_ovr);
    tot = sum + ck;
    send_byte(ck, 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_error", 32'(error), 32'(tot != 8'd0));
    check("done_busy", 32'(busy), 32'd0);
    check("done_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("done_s_ready", 32'(s_ready), 32'd0);
    check("writes_remaining", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("error_hold", 32'(error), 32'(tot != 8'd0));
    check("no_write_after_done", 32'(mem_we), 32'd0);
    $display("load len=%0d sum=%02h ck=%02h error=%0b", len, sum, ck, error);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] w;
    rst_n   = 1'b0;
    start   = 1'b0;
    length  = '0;
    s_data  = 8'd0;
    s_valid = 1'b0;
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic two-word load, good checksum.
    do_load(2, 0, -1, 1'b0, -1);
    // Same data, wrong checksum: words still written, error raised.
    do_load(2, 0, 0, 1'b0, -1);
    // Zero-length load: only the checksum byte; start also clears the previous error.
    do_load(0, 0, -1, 1'b0, -1);
    // Full memory with random gaps, then an oversize request clamped to full memory.
    do_load(256, 1, -1, 1'b1, -1);
    do_load(300, 1, -1, 1'b1, -1);
    // start pulsed mid-load must be ignored.
    do_load(4, 1, -1, 1'b0, 3);

    // Abort after three of four words with an asynchronous reset.
    do_start(4);
    w = '0;
    for (int i = 0; i < 6; i++) begin
      w[8*(i%2) +: 8] = 8'(i);
      if (i % 2 == 1) exp_q.push_back(wr_t'{addr: AW'(i / 2), data: w});
      send_byte(8'(i), 0);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    check("abort_writes_remaining", 32'(exp_q.size()), 32'd0);
    $display("abort reset applied after 3 words");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_load(2, 1, -1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
